// File: rtl/alu_datapath_if.sv
// Operand/decode request and registered-result bundle for alu_datapath.
// Optional flag signals appear only when ALU_DATAPATH_FLAGS_EN is defined.
interface alu_datapath_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [10:0]      opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;

    logic             out_valid;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;
`ifdef ALU_DATAPATH_FLAGS_EN
    logic             negative;
    logic             carry;
    logic             overflow;
`endif

    modport master (
        output in_valid, alu_op, opcode, a, b, pc, imm,
        input  out_valid, alu_ctl, result, zero, pc_plus4, branch_target
`ifdef ALU_DATAPATH_FLAGS_EN
        , input negative, carry, overflow
`endif
    );

    modport slave (
        input  in_valid, alu_op, opcode, a, b, pc, imm,
        output out_valid, alu_ctl, result, zero, pc_plus4, branch_target
`ifdef ALU_DATAPATH_FLAGS_EN
        , output negative, carry, overflow
`endif
    );
endinterface

// File: rtl/alu_datapath.sv
// Single-stage ALU datapath: ALU-control decode, ALU, pc+4 and branch adders, one output register stage.
// Define ALU_DATAPATH_FLAGS_EN to add registered negative/carry/overflow flags.
module alu_datapath #(
    parameter int WIDTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    alu_datapath_if.slave bus
);
    localparam logic [3:0]  CTL_AND   = 4'b0000;
    localparam logic [3:0]  CTL_ORR   = 4'b0001;
    localparam logic [3:0]  CTL_ADD   = 4'b0010;
    localparam logic [3:0]  CTL_SUB   = 4'b0110;
    localparam logic [3:0]  CTL_PASSB = 4'b0111;
    localparam logic [3:0]  CTL_NOR   = 4'b1100;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    localparam int MSB = WIDTH - 1;

    logic [3:0]       alu_ctl_next, alu_ctl_reg;
    logic [WIDTH-1:0] add_res, sub_res;
    logic [WIDTH-1:0] result_next, result_reg;
    logic             zero_next, zero_reg;
    logic [WIDTH-1:0] pc_plus4_next, pc_plus4_reg;
    logic [WIDTH-1:0] branch_target_next, branch_target_reg;
    logic             out_valid_reg;

    always_comb begin
        alu_ctl_next = CTL_ADD;
        case (bus.alu_op)
            2'b01: alu_ctl_next = CTL_PASSB;
            2'b10: begin
                case (bus.opcode)
                    OPC_SUB: alu_ctl_next = CTL_SUB;
                    OPC_AND: alu_ctl_next = CTL_AND;
                    OPC_ORR: alu_ctl_next = CTL_ORR;
                    default: alu_ctl_next = CTL_ADD;   // includes OPC_ADD
                endcase
            end
            default: alu_ctl_next = CTL_ADD;           // memory class and reserved
        endcase
    end

    assign add_res = bus.a + bus.b;
    assign sub_res = bus.a - bus.b;

    always_comb begin
        result_next = '0;
        case (alu_ctl_next)
            CTL_AND:   result_next = bus.a & bus.b;
            CTL_ORR:   result_next = bus.a | bus.b;
            CTL_ADD:   result_next = add_res;
            CTL_SUB:   result_next = sub_res;
            CTL_PASSB: result_next = bus.b;
            CTL_NOR:   result_next = ~(bus.a | bus.b);
            default:   result_next = '0;
        endcase
    end

    assign zero_next          = ~|result_next;
    assign pc_plus4_next      = bus.pc + WIDTH'(4);
    assign branch_target_next = bus.pc + (bus.imm << 2);

`ifdef ALU_DATAPATH_FLAGS_EN
    logic negative_next, carry_next, overflow_next;
    logic negative_reg, carry_reg, overflow_reg;

    // Carry of a subtract is the not-borrow, i.e. a >= b unsigned.
    always_comb begin
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (alu_ctl_next)
            CTL_ADD: begin
                carry_next    = add_res < bus.a;
                overflow_next = (bus.a[MSB] == bus.b[MSB]) && (add_res[MSB] != bus.a[MSB]);
            end
            CTL_SUB: begin
                carry_next    = bus.a >= bus.b;
                overflow_next = (bus.a[MSB] != bus.b[MSB]) && (sub_res[MSB] != bus.a[MSB]);
            end
            default: ;
        endcase
    end

    assign negative_next = result_next[MSB];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg     <= 1'b0;
            alu_ctl_reg       <= '0;
            result_reg        <= '0;
            zero_reg          <= 1'b0;
            pc_plus4_reg      <= '0;
            branch_target_reg <= '0;
`ifdef ALU_DATAPATH_FLAGS_EN
            negative_reg      <= 1'b0;
            carry_reg         <= 1'b0;
            overflow_reg      <= 1'b0;
`endif
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                alu_ctl_reg       <= alu_ctl_next;
                result_reg        <= result_next;
                zero_reg          <= zero_next;
                pc_plus4_reg      <= pc_plus4_next;
                branch_target_reg <= branch_target_next;
`ifdef ALU_DATAPATH_FLAGS_EN
                negative_reg      <= negative_next;
                carry_reg         <= carry_next;
                overflow_reg      <= overflow_next;
`endif
            end
        end
    end

    assign bus.out_valid     = out_valid_reg;
    assign bus.alu_ctl       = alu_ctl_reg;
    assign bus.result        = result_reg;
    assign bus.zero          = zero_reg;
    assign bus.pc_plus4      = pc_plus4_reg;
    assign bus.branch_target = branch_target_reg;
`ifdef ALU_DATAPATH_FLAGS_EN
    assign bus.negative      = negative_reg;
    assign bus.carry         = carry_reg;
    assign bus.overflow      = overflow_reg;
`endif
endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed scenarios plus randomized ops against a behavioural model.
module tb_alu_datapath;
    localparam int W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_datapath_if #(.WIDTH(W)) bus ();
    alu_datapath #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Model of the registered outputs: they follow the last accepted op.
    logic         exp_valid;
    logic [3:0]   exp_ctl;
    logic [W-1:0] exp_res, exp_p4, exp_bt;
    logic         exp_zero;
`ifdef ALU_DATAPATH_FLAGS_EN
    logic         exp_neg, exp_carry, exp_ovf;
`endif

    function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [10:0] opc);
        if (op == 2'b01) return 4'b0111;
        if (op == 2'b10) begin
            if (opc == 11'b11001011000) return 4'b0110;
            if (opc == 11'b10001010000) return 4'b0000;
            if (opc == 11'b10101010000) return 4'b0001;
        end
        return 4'b0010;
    endfunction

    function automatic logic [W-1:0] ref_res(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y);
        case (ctl)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return y;
            4'b1100: return ~(x | y);
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_clear();
        exp_valid = 0; exp_ctl = '0; exp_res = '0; exp_zero = 0; exp_p4 = '0; exp_bt = '0;
`ifdef ALU_DATAPATH_FLAGS_EN
        exp_neg = 0; exp_carry = 0; exp_ovf = 0;
`endif
    endtask

    // Apply one cycle of stimulus, update the model, and return #1 after the capturing edge.
    task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] p, input logic [W-1:0] im);
        bus.in_valid = v; bus.alu_op = op; bus.opcode = opc;
        bus.a = x; bus.b = y; bus.pc = p; bus.imm = im;
        exp_valid = v;
        if (v) begin
            exp_ctl  = ref_ctl(op, opc);
            exp_res  = ref_res(exp_ctl, x, y);
            exp_zero = (exp_res == '0);
            exp_p4   = p + 64'd4;
            exp_bt   = p + im * 4;
`ifdef ALU_DATAPATH_FLAGS_EN
            begin
                logic [W:0] s;
                logic signed [W:0] sg;
                exp_neg = exp_res[W-1]; exp_carry = 0; exp_ovf = 0;
                if (exp_ctl == 4'b0010) begin
                    s = {1'b0, x} + {1'b0, y}; exp_carry = s[W];
                    sg = $signed({x[W-1], x}) + $signed({y[W-1], y}); exp_ovf = sg[W] != sg[W-1];
                end else if (exp_ctl == 4'b0110) begin
                    exp_carry = x >= y;
                    sg = $signed({x[W-1], x}) - $signed({y[W-1], y}); exp_ovf = sg[W] != sg[W-1];
                end
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.pc_plus4, bus.branch_target} !== '0) begin
            errors++; $display("FAIL reset_initial: outputs=%h required all zero",
                {bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.pc_plus4, bus.branch_target});
        end
        reset = 0;
        drive(1, 2'b00, 11'd0, 64'd1, 64'd2, 64'h40, 64'd1);
        checks++;
        if (bus.result !== 64'd3 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_pre_op: result=%h valid=%b required 3/1", bus.result, bus.out_valid);
        end
        bus.a = 64'd7; bus.b = 64'd9; bus.in_valid = 1;
        #3 reset = 1;
        #1;
        checks++;
        if ({bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.pc_plus4, bus.branch_target} !== '0) begin
            errors++; $display("FAIL reset_async: outputs=%h required all zero",
                {bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.pc_plus4, bus.branch_target});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.pc_plus4} !== '0) begin
            errors++; $display("FAIL reset_held: valid=%b result=%h pc_plus4=%h required 0",
                bus.out_valid, bus.result, bus.pc_plus4);
        end
        model_clear();
        bus.in_valid = 0; reset = 0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0) begin
            errors++; $display("FAIL reset_release: valid=%b result=%h required 0/0", bus.out_valid, bus.result);
        end
        drive(1, 2'b10, 11'b10001011000, 64'd10, 64'd20, 64'h0, 64'h0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 64'd30) begin
            errors++; $display("FAIL reset_first_op: valid=%b result=%h required 1/1e", bus.out_valid, bus.result);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_rtype_sub();
        drive(1, 2'b10, 11'b11001011000, 64'd5, 64'd5, 64'h0, 64'h0);
        checks++;
        if (bus.alu_ctl !== 4'b0110 || bus.result !== '0 || bus.zero !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rtype_sub: ctl=%b result=%h zero=%b valid=%b required 0110/0/1/1",
                bus.alu_ctl, bus.result, bus.zero, bus.out_valid);
        end
        $display("test_rtype_sub: ctl=%b result=%h zero=%b", bus.alu_ctl, bus.result, bus.zero);
    endtask

    task automatic test_memory_wrap();
        drive(1, 2'b00, 11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0, 64'h0);
        checks++;
        if (bus.result !== 64'd1 || bus.zero !== 1'b0 || bus.alu_ctl !== 4'b0010) begin
            errors++; $display("FAIL memory_wrap: result=%h zero=%b ctl=%b required 1/0/0010",
                bus.result, bus.zero, bus.alu_ctl);
        end
        $display("test_memory_wrap: result=%h zero=%b", bus.result, bus.zero);
    endtask

    task automatic test_branch_adders();
        drive(1, 2'b01, 11'd0, 64'd0, 64'd1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFD);
        checks++;
        if (bus.pc_plus4 !== 64'h104 || bus.branch_target !== 64'hF4) begin
            errors++; $display("FAIL branch_adders: pc_plus4=%h target=%h required 104/f4",
                bus.pc_plus4, bus.branch_target);
        end
        drive(1, 2'b00, 11'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1);
        checks++;
        if (bus.pc_plus4 !== 64'h0 || bus.branch_target !== 64'h0) begin
            errors++; $display("FAIL branch_wrap: pc_plus4=%h target=%h required 0/0",
                bus.pc_plus4, bus.branch_target);
        end
        $display("test_branch_adders: pc_plus4=%h target=%h", bus.pc_plus4, bus.branch_target);
    endtask

    task automatic test_compare_logic();
        drive(1, 2'b01, 11'd0, 64'h1234, 64'd0, 64'h0, 64'h0);
        checks++;
        if (bus.result !== '0 || bus.zero !== 1'b1 || bus.alu_ctl !== 4'b0111) begin
            errors++; $display("FAIL cbz_pass_b: result=%h zero=%b ctl=%b required 0/1/0111",
                bus.result, bus.zero, bus.alu_ctl);
        end
        drive(1, 2'b10, 11'b10101010000, 64'hF0, 64'h0F, 64'h0, 64'h0);
        checks++;
        if (bus.result !== 64'hFF || bus.alu_ctl !== 4'b0001) begin
            errors++; $display("FAIL orr: result=%h ctl=%b required ff/0001", bus.result, bus.alu_ctl);
        end
        drive(1, 2'b10, 11'b10001010000, 64'hF0, 64'h3C, 64'h0, 64'h0);
        checks++;
        if (bus.result !== 64'h30 || bus.alu_ctl !== 4'b0000) begin
            errors++; $display("FAIL and: result=%h ctl=%b required 30/0000", bus.result, bus.alu_ctl);
        end
        drive(1, 2'b10, 11'b11111111111, 64'd3, 64'd4, 64'h0, 64'h0);
        checks++;
        if (bus.alu_ctl !== 4'b0010 || bus.result !== 64'd7) begin
            errors++; $display("FAIL unknown_opcode: ctl=%b result=%h required 0010/7", bus.alu_ctl, bus.result);
        end
        drive(1, 2'b11, 11'b11001011000, 64'd3, 64'd4, 64'h0, 64'h0);
        checks++;
        if (bus.alu_ctl !== 4'b0010 || bus.result !== 64'd7) begin
            errors++; $display("FAIL reserved_class: ctl=%b result=%h required 0010/7", bus.alu_ctl, bus.result);
        end
        $display("test_compare_logic: last ctl=%b result=%h", bus.alu_ctl, bus.result);
    endtask

    task automatic test_hold();
        logic [3:0]   h_ctl;
        logic [W-1:0] h_res, h_p4, h_bt;
        drive(1, 2'b10, 11'b11001011000, 64'd100, 64'd58, 64'h2000, 64'd5);
        h_ctl = bus.alu_ctl; h_res = bus.result; h_p4 = bus.pc_plus4; h_bt = bus.branch_target;
        checks++;
        if (h_res !== 64'd42 || h_bt !== 64'h2014) begin
            errors++; $display("FAIL hold_setup: result=%h target=%h required 2a/2014", h_res, h_bt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b00, 11'd0, rand64(), rand64(), rand64(), rand64());
            checks++;
            if (bus.out_valid !== 1'b0 || bus.alu_ctl !== h_ctl || bus.result !== h_res ||
                bus.pc_plus4 !== h_p4 || bus.branch_target !== h_bt) begin
                errors++; $display("FAIL hold_cycle%0d: valid=%b result=%h pc_plus4=%h required 0/%h/%h",
                    i, bus.out_valid, bus.result, bus.pc_plus4, h_res, h_p4);
            end
        end
        $display("test_hold: result held at %h", bus.result);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b10, 11'b10001011000, 64'(i), 64'(i * 3), 64'(i * 16), 64'(i));
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 64'(i * 4) || bus.pc_plus4 !== 64'(i * 16 + 4)) begin
                errors++; $display("FAIL back_to_back%0d: valid=%b result=%h required 1/%h",
                    i, bus.out_valid, bus.result, 64'(i * 4));
            end
        end
        $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        logic [10:0]  opc;
        logic [W-1:0] x, y;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: opc = 11'b10001011000;
                1: opc = 11'b11001011000;
                2: opc = 11'b10001010000;
                3: opc = 11'b10101010000;
                default: opc = 11'($urandom());
            endcase
            x = rand64();
            y = ($urandom_range(0, 7) == 0) ? x : rand64();
            drive(($urandom_range(0, 3) != 0), 2'($urandom()), opc, x, y, rand64(), rand64());
            checks++;
            if ({bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.pc_plus4, bus.branch_target} !==
                {exp_valid, exp_ctl, exp_res, exp_zero, exp_p4, exp_bt}) begin
                errors++; $display("FAIL random%0d: valid=%b ctl=%b result=%h zero=%b p4=%h bt=%h required %b %b %h %b %h %h",
                    n, bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.pc_plus4, bus.branch_target,
                    exp_valid, exp_ctl, exp_res, exp_zero, exp_p4, exp_bt);
            end
`ifdef ALU_DATAPATH_FLAGS_EN
            checks++;
            if ({bus.negative, bus.carry, bus.overflow} !== {exp_neg, exp_carry, exp_ovf}) begin
                errors++; $display("FAIL random_flags%0d: nzv=%b%b%b required %b%b%b", n,
                    bus.negative, bus.carry, bus.overflow, exp_neg, exp_carry, exp_ovf);
            end
`endif
        end
        $display("test_random done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        bus.in_valid = 0; bus.alu_op = '0; bus.opcode = '0;
        bus.a = '0; bus.b = '0; bus.pc = '0; bus.imm = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype_sub();
        test_memory_wrap();
        test_branch_adders();
        test_compare_logic();
        test_hold();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter: WIDTH, default 64, datapath width of operands, results and addresses.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operands and decode fields valid this cycle.
REQ-005 alu_op  input  2  control-unit ALU class: 00 memory, 01 compare-branch, 10 R-type, 11 reserved.
REQ-006 opcode  input  11  instruction bits [31:21].
REQ-007 a  input  WIDTH  register operand 1.
REQ-008 b  input  WIDTH  operand 2, register or sign-extended immediate, already muxed.
REQ-009 pc  input  WIDTH  current program counter.
REQ-010 imm  input  WIDTH  sign-extended branch offset, in words.
REQ-011 out_valid  output  1  registered outputs hold a new result.
REQ-012 alu_ctl  output  4  decoded ALU control code.
REQ-013 result  output  WIDTH  ALU result.
REQ-014 zero  output  1  high when result is all zeros.
REQ-015 pc_plus4  output  WIDTH  pc + 4.
REQ-016 branch_target  output  WIDTH  pc + (imm << 2).

Function
REQ-017 ALU-control decode SHALL map alu_op 00 to 0010 (add) and alu_op 01 to 0111 (pass b).
REQ-018 With alu_op 10, the opcode SHALL decode as follows: 10001011000 to 0010 (ADD); 11001011000 to 0110 (SUB); 10001010000 to 0000 (AND); 10101010000 to 0001 (ORR); any other opcode to 0010.
REQ-019 alu_op 11 SHALL decode to 0010.
REQ-020 ALU codes SHALL produce these results: 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 0111 b; 1100 ~(a|b); any other code produces 0.
REQ-021 All additions and subtractions SHALL be modulo 2^WIDTH (wrap-around, carry discarded).
REQ-022 The pc_plus4 adder SHALL compute pc+4 modulo 2^WIDTH.
REQ-023 The branch adder SHALL compute pc + (imm shifted left 2, low WIDTH bits kept) modulo 2^WIDTH.
REQ-024 zero SHALL equal the NOR-reduction of the same-cycle result value being registered.
REQ-025 alu_ctl, result, zero, pc_plus4 and branch_target SHALL be registered with 1-cycle latency, loading only on a clk edge where in_valid=1.
REQ-026 When in_valid=0, the data outputs SHALL hold their previous values.
REQ-027 out_valid SHALL be a register of in_valid (1-cycle delay), so back-to-back valid inputs yield back-to-back valid outputs.
REQ-028 The decode and the arithmetic SHALL be purely combinational ahead of the output registers, with no other state.

Reset
REQ-029 While reset=1, all outputs SHALL be 0 immediately, independent of clk: out_valid, alu_ctl, result, zero, pc_plus4 and branch_target.
REQ-030 An operation in flight when reset asserts SHALL be discarded; the first valid input after reset deasserts SHALL produce output one cycle later.

Configuration
REQ-031 Macro ALU_DATAPATH_FLAGS_EN: when defined, add registered outputs negative (result MSB), carry (carry-out of add, or not-borrow of sub) and overflow (signed overflow of add/sub); these are 0 for other codes and 0 on reset.
REQ-032 Without ALU_DATAPATH_FLAGS_EN, those ports and their logic SHALL be absent.

Verification
REQ-033 Reset: assert reset mid-stream with in_valid=1 -> all outputs 0 at once; out_valid is 0 on the first edge after release.
REQ-034 R-type: alu_op=10, opcode=11001011000, a=5, b=5 -> one cycle later alu_ctl=0110, result=0, zero=1, out_valid=1.
REQ-035 Memory class: alu_op=00, a=0xFFFFFFFFFFFFFFFF, b=2 -> result=1 (wrap), zero=0, alu_ctl=0010.
REQ-036 Branch adders: pc=0x100, imm=-3 (all ones except low bits 0xFD) -> pc_plus4=0x104, branch_target=0xF4.
REQ-037 Compare-branch and logic: alu_op=01, b=0 -> result=0, zero=1; alu_op=10, opcode=10101010000, a=0xF0, b=0x0F -> result=0xFF; unknown opcode -> alu_ctl=0010.
REQ-038 Hold: in_valid=0 for 3 cycles after a valid op -> outputs unchanged, out_valid=0.
